exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception/interrupt sequencer in the M stage, working with the per-stage ExcCode chain (F/D/E exception units feed `m_exccode`).
- Owns the CP0 registers SR(12), Cause(13), EPC(14) and PRId(15), and arbitrates between hardware interrupts, pipeline exceptions and `eret`.
- Kills the M-stage instruction, then drives a one-cycle flush and PC redirect to the handler vector or to EPC.

Parameters:
- VEC_ADDR, 32'h0000_4180, handler entry PC.
- PRID_VAL, 32'h4554_4850, read-only PRId value.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- m_valid  in  1  M stage holds a real instruction (not a bubble).
- m_pc  in  32  PC of the M-stage instruction.
- m_bd  in  1  M-stage instruction sits in a branch delay slot.
- m_exccode  in  5  ExcCode[6:2] from the exception chain; 0 = none.
- m_eret  in  1  M-stage instruction is `eret`.
- hwint  in  6  external interrupt lines [7:2], level-sensitive.
- cp0_addr  in  5  mtc0/mfc0 register index.
- cp0_we  in  1  mtc0 write strobe.
- cp0_wdata  in  32  mtc0 data.
- cp0_rdata  out  32  mfc0 data, combinational.
- m_kill  out  1  suppress the M-stage commit this cycle (memory write, register write).
- flush  out  1  clear F/D/E/M pipeline registers.
- redirect_valid  out  1  load `redirect_pc` into the PC.
- redirect_pc  out  32  target PC.
- exl  out  1  SR.EXL.

Behaviour:
- Reset (reset==0, async) clears:
  - SR: IM[15:10], EXL[1], IE[0].
  - Cause: BD[31], IP[15:10], ExcCode[6:2].
  - EPC, FSM state (RUN), `m_kill`, `flush`, `redirect_valid`, `redirect_pc`.
- Reset asserted mid-FLUSH/ERET aborts the redirect; FSM returns to RUN.
- Cause.IP <= hwint every cycle in every state, independent of any request.
- Request terms:
  - int_req = |(hwint & SR.IM) & SR.IE & !SR.EXL.
  - exc_req = m_valid & (m_exccode != 0) & !SR.EXL.
  - req = int_req | exc_req. Interrupt has priority over exception.
- `m_kill` = req in RUN, combinational. It is 0 in every other state.
- FSM states: RUN, FLUSH, ERET.
- RUN, req at the clock edge:
  - EPC <= m_bd ? m_pc-4 : m_pc, with bits [1:0] forced to 0.
  - Cause.BD <= m_bd.
  - Cause.ExcCode <= int_req ? 0 : m_exccode.
  - SR.EXL <= 1.
  - Next state FLUSH.
- RUN, !req & m_valid & m_eret at the clock edge: SR.EXL <= 0; next state ERET.
- FLUSH lasts exactly 1 cycle: flush=1, redirect_valid=1, redirect_pc=VEC_ADDR; then RUN.
- ERET lasts exactly 1 cycle: flush=1, redirect_valid=1, redirect_pc=EPC (current register value); then RUN.
- In FLUSH and ERET, all request, eret and mtc0 inputs are ignored; they come from flushed stages.
- mtc0, honoured only in RUN with !req:
  - 12: IM, EXL and IE fields written.
  - 14: EPC written, bits [1:0] forced to 0.
  - 13, 15 and all other indices: write ignored.
- Simultaneous cases:
  - req with cp0_we: the write is dropped and exception state wins.
  - req with m_eret: the exception is taken.
- mtc0 EPC followed by `eret` in the next cycle: redirect uses the new EPC.
- cp0_rdata mux, unmapped indices read 0:
  - 12 → {16'b0, IM, 8'b0, EXL, IE}.
  - 13 → {BD, 15'b0, IP, 3'b0, ExcCode, 2'b0}.
  - 14 → EPC.
  - 15 → PRID_VAL.

Optional Feature:
- Macro: EXC_CTRL_EXC_CNT_EN.
- Defined: a 32-bit counter at CP0 index 22.
  - Increments on each RUN→FLUSH transition; wraps 0xFFFF_FFFF→0.
  - Reset value 0; read-only (mtc0 to 22 ignored).
- Undefined: no counter register; index 22 reads 0.

Decomposition:
- Package cp0_pkg holds:
  - Register indices SR=12, CAUSE=13, EPC=14, PRID=15, CNT=22.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12.
  - FSM state enum {RUN, FLUSH, ERET}.
- One sub-module, cp0_regs: SR/Cause/EPC storage, write decode and read mux.
- The FSM and request logic stay in exc_ctrl.

Test Plan:
- E-stage overflow:
  - Stimulus: m_valid=1, m_pc=0x3008, m_exccode=12, m_bd=0.
  - Same cycle: m_kill=1.
  - Next cycle: flush=1, redirect_pc=0x4180.
  - Afterwards: EPC=0x3008, Cause reads 0x0000_0030, exl=1.
- Delay-slot exception: m_pc=0x3010, m_bd=1, m_exccode=10 → EPC=0x300C, Cause.BD=1, ExcCode=10.
- Interrupt priority:
  - Setup: SR=0x0000_0401, hwint=6'b000001, together with m_exccode=12.
  - Required: ExcCode=0 and Cause.IP[10]=1.
  - With SR.EXL=1 the same stimulus gives m_kill=0.
- mtc0 then eret:
  - Stimulus: mtc0 EPC=0x3020; eret the next cycle.
  - Required: ERET cycle drives redirect_pc=0x3020 and flush=1; exl=0 afterwards.
- Reset mid-FLUSH: reset pulsed low in the FLUSH cycle → flush=0, redirect_valid=0, EPC=0, SR=0 immediately (asynchronous).
- EXC_CTRL_EXC_CNT_EN defined, 3 exceptions taken → index 22 reads 3; undefined build reads 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, ExcCodes, sequencer states and field layouts.
package cp0_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned IRQ_W = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_SR    = 5'd12;
  localparam logic [REG_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [REG_W-1:0] REG_EPC   = 5'd14;
  localparam logic [REG_W-1:0] REG_PRID  = 5'd15;
  localparam logic [REG_W-1:0] REG_CNT   = 5'd22;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    ERET  = 2'd2
  } state_e;

  typedef struct packed {
    logic [IRQ_W-1:0] im;
    logic             exl;
    logic             ie;
  } sr_t;

  typedef struct packed {
    logic             bd;
    logic [IRQ_W-1:0] ip;
    logic [EXC_W-1:0] code;
  } cause_t;

  // EPC is always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// CP0 SR/Cause/EPC storage, mtc0 write decode and mfc0 read mux.
// EXC_CTRL_EXC_CNT_EN adds a read-only taken-exception counter at index 22.
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [XLEN-1:0] PRID_VAL = 32'h4554_4850
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_W-1:0]  hwint,
  input  logic              take,
  input  logic              take_int,
  input  logic              take_bd,
  input  logic [XLEN-1:0]   take_pc,
  input  logic [EXC_W-1:0]  take_code,
  input  logic              eret_clr,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [REG_W-1:0]  rd_addr,
  output logic [XLEN-1:0]   rd_data,
  output logic [IRQ_W-1:0]  sr_im,
  output logic              sr_exl,
  output logic              sr_ie,
  output logic [XLEN-1:0]   epc
);

  sr_t             sr_q;
  cause_t          cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] take_epc;

  assign take_epc = take_bd ? (take_pc - 32'd4) : take_pc;

  // SR: exception entry sets EXL; eret clears it after any same-cycle mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (take) begin
      sr_q.exl <= 1'b1;
    end else begin
      if (wr_en && (wr_addr == REG_SR)) begin
        sr_q.im  <= wr_data[15:10];
        sr_q.exl <= wr_data[1];
        sr_q.ie  <= wr_data[0];
      end
      if (eret_clr) begin
        sr_q.exl <= 1'b0;
      end
    end
  end

  // Cause: IP tracks the pins continuously; BD/ExcCode captured on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_q <= '0;
    end else begin
      cause_q.ip <= hwint;
      if (take) begin
        cause_q.bd   <= take_bd;
        cause_q.code <= take_int ? EXC_INT : take_code;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= '0;
    end else if (take) begin
      epc_q <= align_pc(take_epc);
    end else if (wr_en && (wr_addr == REG_EPC)) begin
      epc_q <= align_pc(wr_data);
    end
  end

`ifdef EXC_CTRL_EXC_CNT_EN
  logic [XLEN-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_SR:    rd_data = {16'b0, sr_q.im, 8'b0, sr_q.exl, sr_q.ie};
      REG_CAUSE: rd_data = {cause_q.bd, 15'b0, cause_q.ip, 3'b0, cause_q.code, 2'b0};
      REG_EPC:   rd_data = epc_q;
      REG_PRID:  rd_data = PRID_VAL;
`ifdef EXC_CTRL_EXC_CNT_EN
      REG_CNT:   rd_data = cnt_q;
`endif
      default:   rd_data = '0;
    endcase
  end

  assign sr_im  = sr_q.im;
  assign sr_exl = sr_q.exl;
  assign sr_ie  = sr_q.ie;
  assign epc    = epc_q;

endmodule

// File: rtl/exc_ctrl.sv
// M-stage exception/interrupt sequencer: arbitrates requests, kills M, then flushes and redirects.
// Optional EXC_CTRL_EXC_CNT_EN enables the taken-exception counter in cp0_regs.
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [XLEN-1:0] VEC_ADDR = 32'h0000_4180,
  parameter logic [XLEN-1:0] PRID_VAL = 32'h4554_4850
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [XLEN-1:0]   m_pc,
  input  logic              m_bd,
  input  logic [EXC_W-1:0]  m_exccode,
  input  logic              m_eret,
  input  logic [IRQ_W-1:0]  hwint,
  input  logic [REG_W-1:0]  cp0_addr,
  input  logic              cp0_we,
  input  logic [XLEN-1:0]   cp0_wdata,
  output logic [XLEN-1:0]   cp0_rdata,
  output logic              m_kill,
  output logic              flush,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              exl
);

  state_e          state_q;
  state_e          state_d;
  logic [IRQ_W-1:0] sr_im;
  logic            sr_exl;
  logic            sr_ie;
  logic [XLEN-1:0] epc;
  logic            int_req;
  logic            exc_req;
  logic            req;
  logic            run;
  logic            take;
  logic            eret_go;
  logic            wr_en;

  // Requests are masked while EXL is set; interrupt outranks exception.
  assign int_req = (|(hwint & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = m_valid & (m_exccode != '0) & ~sr_exl;
  assign req     = int_req | exc_req;
  assign run     = (state_q == RUN);
  assign take    = run & req;
  assign eret_go = run & ~req & m_valid & m_eret;
  assign wr_en   = run & ~req & cp0_we;

  cp0_regs #(
    .PRID_VAL (PRID_VAL)
  ) u_cp0_regs (
    .clk       (clk),
    .reset     (reset),
    .hwint     (hwint),
    .take      (take),
    .take_int  (int_req),
    .take_bd   (m_bd),
    .take_pc   (m_pc),
    .take_code (m_exccode),
    .eret_clr  (eret_go),
    .wr_en     (wr_en),
    .wr_addr   (cp0_addr),
    .wr_data   (cp0_wdata),
    .rd_addr   (cp0_addr),
    .rd_data   (cp0_rdata),
    .sr_im     (sr_im),
    .sr_exl    (sr_exl),
    .sr_ie     (sr_ie),
    .epc       (epc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (take) begin
          state_d = FLUSH;
        end else if (eret_go) begin
          state_d = ERET;
        end
      end
      FLUSH:   state_d = RUN;
      ERET:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Redirect outputs decode the state register only, so reset drops them at once.
  always_comb begin
    m_kill         = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      RUN: m_kill = req;
      FLUSH: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = VEC_ADDR;
      end
      ERET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = epc;
      end
      default: ;
    endcase
  end

  assign exl = sr_exl;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: stimulus queues expected per-cycle observations, a negedge monitor checks them.
module tb_exc_ctrl;
  import cp0_pkg::*;

  localparam bit [5:0] C_K  = 6'h01;
  localparam bit [5:0] C_F  = 6'h02;
  localparam bit [5:0] C_RV = 6'h04;
  localparam bit [5:0] C_RP = 6'h08;
  localparam bit [5:0] C_X  = 6'h10;
  localparam bit [5:0] C_RD = 6'h20;
  localparam bit [5:0] C_RDR = C_F | C_RV | C_RP;

`ifdef EXC_CTRL_EXC_CNT_EN
  localparam logic [31:0] EXP_CNT = 32'd3;
`else
  localparam logic [31:0] EXP_CNT = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic [5:0]  hwint;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        m_kill;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exl;

  typedef struct {
    string       name;
    bit [5:0]    chk;
    logic        kill;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        exl;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  logic probe = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  exc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .m_valid        (m_valid),
    .m_pc           (m_pc),
    .m_bd           (m_bd),
    .m_exccode      (m_exccode),
    .m_eret         (m_eret),
    .hwint          (hwint),
    .cp0_addr       (cp0_addr),
    .cp0_we         (cp0_we),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .m_kill         (m_kill),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exl            (exl)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
  endtask

  // Monitor: pops one expectation per probed cycle; any unprobed redirect is an error.
  always @(negedge clk) begin
    if (probe) begin
      if (q.size() == 0) begin
        cmp("scoreboard", "empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ((e.chk & C_K)  != 0) cmp(e.name, "m_kill",         32'(m_kill),         32'(e.kill));
        if ((e.chk & C_F)  != 0) cmp(e.name, "flush",          32'(flush),          32'(e.flush));
        if ((e.chk & C_RV) != 0) cmp(e.name, "redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if ((e.chk & C_RP) != 0) cmp(e.name, "redirect_pc",    redirect_pc,         e.rpc);
        if ((e.chk & C_X)  != 0) cmp(e.name, "exl",            32'(exl),            32'(e.exl));
        if ((e.chk & C_RD) != 0) cmp(e.name, "cp0_rdata",      cp0_rdata,           e.rdata);
      end
    end else if (redirect_valid) begin
      cmp("unexpected_redirect", "redirect_valid", 32'(redirect_valid), 32'd0);
    end
  end

  task automatic ex(input string nm, input bit [5:0] chk, input logic kill, input logic fl,
                    input logic rv, input logic [31:0] rpc, input logic x, input logic [31:0] rd);
    exp_t e;
    e.name = nm; e.chk = chk; e.kill = kill; e.flush = fl; e.rv = rv;
    e.rpc = rpc; e.exl = x; e.rdata = rd;
    q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic idle();
    m_valid = 1'b0; m_bd = 1'b0; m_exccode = 5'd0; m_eret = 1'b0;
    cp0_we = 1'b0; cp0_wdata = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    cyc();
    cp0_we = 1'b0;
  endtask

  task automatic raise(input logic [31:0] pc, input logic bd, input logic [4:0] code);
    idle();
    m_valid = 1'b1; m_pc = pc; m_bd = bd; m_exccode = code;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] v);
    idle();
    cp0_addr = a;
    ex(nm, C_RD, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, v);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; hwint = 6'd0; cp0_addr = 5'd0; m_pc = 32'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    cp0_addr = REG_SR;
    ex("reset_state", C_K | C_RDR | C_X | C_RD, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();

    // E-stage overflow
    raise(32'h3008, 1'b0, EXC_OV);
    ex("ov_kill", C_K | C_X, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    ex("ov_flush", C_K | C_RDR, 1'b0, 1'b1, 1'b1, 32'h4180, 1'b0, 32'd0);
    cyc();
    cp0_addr = REG_EPC;
    ex("ov_epc", C_RD | C_X, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3008);
    cyc();
    rd("ov_cause", REG_CAUSE, 32'h0000_0030);

    // Delay-slot exception
    mtc0(REG_SR, 32'd0);
    raise(32'h3010, 1'b1, EXC_RI);
    ex("bd_kill", C_K, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    ex("bd_flush", C_RDR, 1'b0, 1'b1, 1'b1, 32'h4180, 1'b0, 32'd0);
    cyc();
    rd("bd_epc", REG_EPC, 32'h300C);
    rd("bd_cause", REG_CAUSE, 32'h8000_0028);

    // Interrupt outranks a simultaneous exception
    mtc0(REG_SR, 32'h0000_0401);
    raise(32'h3040, 1'b0, EXC_OV);
    hwint = 6'b000001;
    ex("int_kill", C_K, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    ex("int_flush", C_RDR, 1'b0, 1'b1, 1'b1, 32'h4180, 1'b0, 32'd0);
    cyc();
    rd("int_cause", REG_CAUSE, 32'h0000_0400);
    raise(32'h3044, 1'b0, EXC_OV);
    ex("exl_masks_kill", C_K | C_X, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
    cyc();
    idle();
    hwint = 6'd0;
    ex("exl_no_redirect", C_RDR, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();

    // mtc0 EPC then eret: redirect takes the freshly written EPC
    mtc0(REG_EPC, 32'h0000_3023);
    idle();
    m_valid = 1'b1; m_eret = 1'b1;
    ex("eret_nokill", C_K, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    ex("eret_redirect", C_RDR | C_K, 1'b0, 1'b1, 1'b1, 32'h3020, 1'b0, 32'd0);
    cyc();
    cp0_addr = REG_SR;
    ex("eret_sr", C_X | C_RD, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0000_0401);
    cyc();

    // mtc0 in the same cycle as a taken exception is dropped
    raise(32'h3050, 1'b0, EXC_ADEL);
    cp0_we = 1'b1; cp0_addr = REG_EPC; cp0_wdata = 32'h0000_7777;
    ex("wr_drop_kill", C_K, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    ex("wr_drop_flush", C_RDR, 1'b0, 1'b1, 1'b1, 32'h4180, 1'b0, 32'd0);
    cyc();
    rd("wr_drop_epc", REG_EPC, 32'h3050);
    rd("adel_cause", REG_CAUSE, 32'h0000_0010);
    mtc0(REG_SR, 32'h0000_0401);

    // Asynchronous reset in the middle of FLUSH
    raise(32'h3060, 1'b0, EXC_ADES);
    ex("rst_pre_kill", C_K, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    idle();
    cp0_addr = REG_EPC;
    #1 reset = 1'b0;
    ex("rst_mid_flush", C_RDR | C_RD | C_X, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc();
    rd("rst_sr", REG_SR, 32'd0);
    reset = 1'b1;
    rd("rst_cause", REG_CAUSE, 32'd0);

    // Three exceptions for the counter, plus ignored writes
    for (int i = 0; i < 3; i++) begin
      raise(32'h3100 + 32'(i * 8), 1'b0, (i == 0) ? EXC_OV : ((i == 1) ? EXC_RI : EXC_ADEL));
      ex("cnt_kill", C_K, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      cyc();
      idle();
      ex("cnt_flush", C_RDR, 1'b0, 1'b1, 1'b1, 32'h4180, 1'b0, 32'd0);
      cyc();
      mtc0(REG_SR, 32'd0);
    end
    mtc0(REG_CNT, 32'h0000_0055);
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    rd("cnt_value", REG_CNT, EXP_CNT);
    rd("cause_ro", REG_CAUSE, 32'h0000_0010);
    rd("prid", REG_PRID, 32'h4554_4850);
    rd("unmapped", 5'd5, 32'd0);

    repeat (2) cyc();
    if (q.size() != 0) cmp("scoreboard", "leftover", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
